// File: rtl/ctrl_fsm.sv
// Multi-cycle MIPS-style controller: fetch/decode/execute sequencing with a debug state output.
// Optional macro CTRL_SHIFT_EN enables the sll/srl/sra R-type functs.
module ctrl_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       IorD,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       EXTOp,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [4:0] ALUOp,
    output logic       Illegal,
    output logic [3:0] State
);

    // ALU operation codes, mirroring the ALUOp_* encodings shared with the datapath
    localparam logic [4:0] ALUOP_NOP  = 5'd0;
    localparam logic [4:0] ALUOP_ADD  = 5'd1;
    localparam logic [4:0] ALUOP_SUB  = 5'd2;
    localparam logic [4:0] ALUOP_SUBU = 5'd3;
    localparam logic [4:0] ALUOP_AND  = 5'd4;
    localparam logic [4:0] ALUOP_OR   = 5'd5;
    localparam logic [4:0] ALUOP_SLT  = 5'd6;
    localparam logic [4:0] ALUOP_SLL  = 5'd7;
    localparam logic [4:0] ALUOP_SRL  = 5'd8;
    localparam logic [4:0] ALUOP_SRA  = 5'd9;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        REXE   = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        IEXE   = 4'd10,
        IWB    = 4'd11
    } state_t;

    state_t state, next_state;

    logic       r_ok;
    logic       r_shift;
    logic [4:0] r_aluop;

    always_comb begin
        r_ok    = 1'b1;
        r_shift = 1'b0;
        r_aluop = ALUOP_NOP;
        case (Funct)
            6'b100001: r_aluop = ALUOP_ADD;
            6'b100000: r_aluop = ALUOP_ADD;
            6'b100011: r_aluop = ALUOP_SUBU;
            6'b100010: r_aluop = ALUOP_SUB;
            6'b100100: r_aluop = ALUOP_AND;
            6'b100101: r_aluop = ALUOP_OR;
            6'b101010: r_aluop = ALUOP_SLT;
`ifdef CTRL_SHIFT_EN
            6'b000000: begin r_aluop = ALUOP_SLL; r_shift = 1'b1; end
            6'b000010: begin r_aluop = ALUOP_SRL; r_shift = 1'b1; end
            6'b000011: begin r_aluop = ALUOP_SRA; r_shift = 1'b1; end
`endif
            default:   r_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= next_state;
    end

    always_comb begin
        next_state = FETCH;
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        EXTOp      = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        PCSource   = 2'b00;
        ALUOp      = ALUOP_NOP;
        Illegal    = 1'b0;
        // Outputs stay quiet for the whole of reset even though state already reads FETCH
        if (!rst) begin
            case (state)
                FETCH: begin
                    IRWrite    = 1'b1;
                    ALUSrcB    = 2'b01;
                    ALUOp      = ALUOP_ADD;
                    PCWrite    = 1'b1;
                    next_state = DECODE;
                end
                DECODE: begin
                    ALUSrcB = 2'b11;
                    EXTOp   = 1'b1;
                    ALUOp   = ALUOP_ADD;
                    case (Op)
                        OP_RTYPE:        if (r_ok) next_state = REXE;
                                         else      Illegal    = 1'b1;
                        OP_LW, OP_SW:    next_state = MEMADR;
                        OP_BEQ:          next_state = BRANCH;
                        OP_J:            next_state = JUMP;
                        OP_ORI, OP_ADDI: next_state = IEXE;
                        default:         Illegal    = 1'b1;
                    endcase
                end
                MEMADR: begin
                    ALUSrcA    = 2'b01;
                    ALUSrcB    = 2'b10;
                    EXTOp      = 1'b1;
                    ALUOp      = ALUOP_ADD;
                    next_state = (Op == OP_SW) ? MEMWR : MEMRD;
                end
                MEMRD: begin
                    IorD       = 1'b1;
                    next_state = MEMWB;
                end
                MEMWB: begin
                    MemtoReg = 1'b1;
                    RegWrite = 1'b1;
                end
                MEMWR: begin
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                end
                REXE: begin
                    ALUSrcA    = r_shift ? 2'b10 : 2'b01;
                    ALUOp      = r_aluop;
                    next_state = RWB;
                end
                RWB: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                end
                BRANCH: begin
                    ALUSrcA  = 2'b01;
                    ALUOp    = ALUOP_SUB;
                    PCSource = 2'b01;
                    PCWrite  = Zero;
                end
                JUMP: begin
                    PCSource = 2'b10;
                    PCWrite  = 1'b1;
                end
                IEXE: begin
                    ALUSrcA    = 2'b01;
                    ALUSrcB    = 2'b10;
                    EXTOp      = (Op != OP_ORI);
                    ALUOp      = (Op == OP_ORI) ? ALUOP_OR : ALUOP_ADD;
                    next_state = IWB;
                end
                IWB: RegWrite = 1'b1;
                default: next_state = FETCH;
            endcase
        end
    end

    assign State = state;

endmodule

// File: tb/tb_ctrl_fsm.sv
// Directed self-checking bench for ctrl_fsm; inputs change and outputs are sampled away from posedge.
module tb_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       PCWrite, IRWrite, IorD, MemWrite, RegWrite, RegDst, MemtoReg, EXTOp, Illegal;
    logic [1:0] ALUSrcA, ALUSrcB, PCSource;
    logic [4:0] ALUOp;
    logic [3:0] State;

    localparam logic [4:0] NOP = 5'd0, ADD = 5'd1, SUB = 5'd2, OR_ = 5'd5, SRA = 5'd9;

    int n_checks = 0;
    int n_errors = 0;

    ctrl_fsm dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .EXTOp(EXTOp),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp),
        .Illegal(Illegal), .State(State)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [3:0] wen();
        return {PCWrite, IRWrite, MemWrite, RegWrite};
    endfunction

    initial begin
        rst = 1'b1; Op = 6'b0; Funct = 6'b100001; Zero = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state", State, 0);
        check("rst_wen", wen(), 0);
        check("rst_aluop", ALUOp, NOP);
        check("rst_srcb", ALUSrcB, 0);

        rst = 1'b0;
        Op  = 6'b100011;
        #1;
        check("fetch_wen", wen(), 4'b1100);
        check("fetch_srcb", ALUSrcB, 2'b01);
        check("fetch_aluop", ALUOp, ADD);
        check("fetch_iord", IorD, 0);

        // lw: 0,1,2,3,4,0
        step(); check("lw_s1", State, 1);
        check("lw_dec_srcb", ALUSrcB, 2'b11);
        check("lw_dec_ext", EXTOp, 1);
        step(); check("lw_s2", State, 2);
        check("lw_adr_srcb", ALUSrcB, 2'b10);
        check("lw_adr_srca", ALUSrcA, 2'b01);
        step(); check("lw_s3", State, 3);
        check("lw_rd_iord", IorD, 1);
        check("lw_rd_wen", wen(), 0);
        step(); check("lw_s4", State, 4);
        check("lw_wb_regwr", RegWrite, 1);
        check("lw_wb_m2r", MemtoReg, 1);
        check("lw_wb_dst", RegDst, 0);
        step(); check("lw_s0", State, 0);
        check("lw_end_m2r", MemtoReg, 0);

        // beq taken, then Zero drops mid-state: PCWrite follows combinationally
        Op = 6'b000100; Zero = 1'b1;
        step(); check("beq1_s1", State, 1);
        step(); check("beq1_s8", State, 8);
        check("beq1_pcw", PCWrite, 1);
        check("beq1_pcsrc", PCSource, 2'b01);
        check("beq1_aluop", ALUOp, SUB);
        Zero = 1'b0; #1;
        check("beq_mealy", PCWrite, 0);
        step(); check("beq1_s0", State, 0);
        step(); step(); check("beq0_s8", State, 8);
        check("beq0_pcw", PCWrite, 0);
        step(); check("beq0_s0", State, 0);

        // sra
        Op = 6'b000000; Funct = 6'b000011;
        step(); check("sra_s1", State, 1);
`ifdef CTRL_SHIFT_EN
        check("sra_ill", Illegal, 0);
        step(); check("sra_s6", State, 6);
        check("sra_srca", ALUSrcA, 2'b10);
        check("sra_aluop", ALUOp, SRA);
        step(); check("sra_s7", State, 7);
        step(); check("sra_s0", State, 0);
`else
        check("sra_ill", Illegal, 1);
        check("sra_ill_wen", wen(), 0);
        step(); check("sra_s0", State, 0);
        check("sra_ill_end", Illegal, 0);
`endif

        // sub
        Funct = 6'b100010;
        step(); check("sub_ill", Illegal, 0);
        step(); check("sub_s6", State, 6);
        check("sub_srca", ALUSrcA, 2'b01);
        check("sub_srcb", ALUSrcB, 2'b00);
        check("sub_aluop", ALUOp, SUB);
        step(); check("sub_s7", State, 7);
        check("sub_regdst", RegDst, 1);
        check("sub_regwr", RegWrite, 1);
        step(); check("sub_s0", State, 0);

        // unsupported funct
        Funct = 6'b111111;
        step(); check("badf_ill", Illegal, 1);
        step(); check("badf_s0", State, 0);

        // ori
        Op = 6'b001101;
        step(); step(); check("ori_s10", State, 10);
        check("ori_ext", EXTOp, 0);
        check("ori_aluop", ALUOp, OR_);
        check("ori_srcb", ALUSrcB, 2'b10);
        step(); check("ori_s11", State, 11);
        check("ori_regwr", RegWrite, 1);
        check("ori_regdst", RegDst, 0);
        check("ori_m2r", MemtoReg, 0);
        step(); check("ori_s0", State, 0);

        // addi
        Op = 6'b001000;
        step(); step(); check("addi_s10", State, 10);
        check("addi_ext", EXTOp, 1);
        check("addi_aluop", ALUOp, ADD);
        step(); step(); check("addi_s0", State, 0);

        // illegal opcode
        Op = 6'b111111;
        step(); check("ill_s1", State, 1);
        check("ill_pulse", Illegal, 1);
        check("ill_wen", wen(), 0);
        step(); check("ill_s0", State, 0);
        check("ill_gone", Illegal, 0);

        // j
        Op = 6'b000010;
        step(); step(); check("j_s9", State, 9);
        check("j_pcw", PCWrite, 1);
        check("j_pcsrc", PCSource, 2'b10);
        step(); check("j_s0", State, 0);

        // sw with async reset in MEMWR
        Op = 6'b101011;
        step(); step(); step(); check("sw_s5", State, 5);
        check("sw_memwr", MemWrite, 1);
        check("sw_iord", IorD, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_memwr", MemWrite, 0);
        check("arst_state", State, 0);
        check("arst_wen", wen(), 0);
        check("arst_aluop", ALUOp, NOP);
        step();
        check("arst_hold_state", State, 0);
        check("arst_hold_wen", wen(), 0);
        rst = 1'b0; #1;
        check("rel_fetch_ir", IRWrite, 1);
        check("rel_state", State, 0);
        step(); check("rel_s1", State, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
